// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the MEM pipeline stage and a variable-latency data memory.
// One access in flight at a time: IDLE accepts, ACCESS waits for mem_ack or timeout, RESP pulses the result.
module mem_access_ctrl #(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state, state_next;

    logic                 lat_we;
    logic [2:0]           lat_type;
    logic [31:0]          lat_addr;
    logic [31:0]          lat_wdata;
    logic [TIMEOUT_W-1:0] cnt;
    logic [31:0]          resp_data_q;
    logic                 resp_err_q;

    logic                 accept;
    logic                 legal;
    logic                 timeout_hit;
    logic [7:0]           load_byte;
    logic [15:0]          load_half;
    logic [31:0]          load_data;
    logic [31:0]          store_data;
    logic [3:0]           store_be;

    assign accept      = req_valid && (state == IDLE);
    assign timeout_hit = (cnt == TIMEOUT_W'(TIMEOUT - 1));

    // Legality of the incoming request decides between a memory access and an immediate error.
    always_comb begin
        legal = 1'b0;
        case (req_type)
            3'b000:         legal = (req_addr[1:0] == 2'b00);
            3'b001, 3'b101: legal = 1'b1;
            3'b010, 3'b110: legal = ~req_addr[0];
            default:        legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = legal ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (mem_ack || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // An ack in the final timeout cycle is checked first so it completes the access successfully.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_we      <= 1'b0;
            lat_type    <= 3'b000;
            lat_addr    <= 32'h0;
            lat_wdata   <= 32'h0;
            cnt         <= '0;
            resp_data_q <= 32'h0;
            resp_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        lat_we      <= req_we;
                        lat_type    <= req_type;
                        lat_addr    <= req_addr;
                        lat_wdata   <= req_wdata;
                        resp_data_q <= 32'h0;
                        resp_err_q  <= ~legal;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        resp_data_q <= lat_we ? 32'h0 : load_data;
                        resp_err_q  <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_data_q <= 32'h0;
                        resp_err_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + TIMEOUT_W'(1);
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        load_byte = mem_rdata[7:0];
        case (lat_addr[1:0])
            2'b00: load_byte = mem_rdata[7:0];
            2'b01: load_byte = mem_rdata[15:8];
            2'b10: load_byte = mem_rdata[23:16];
            2'b11: load_byte = mem_rdata[31:24];
            default: load_byte = mem_rdata[7:0];
        endcase
        load_half = lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        load_data = mem_rdata;
        case (lat_type)
            3'b001:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b101:  load_data = {24'h0, load_byte};
            3'b010:  load_data = {{16{load_half[15]}}, load_half};
            3'b110:  load_data = {16'h0, load_half};
            default: load_data = mem_rdata;
        endcase
    end

    // Signedness only matters for loads, so stores decode just the size bits.
    always_comb begin
        store_data = lat_wdata;
        store_be   = 4'b1111;
        case (lat_type[1:0])
            2'b01: begin
                store_data = {4{lat_wdata[7:0]}};
                store_be   = 4'b0001 << lat_addr[1:0];
            end
            2'b10: begin
                store_data = {2{lat_wdata[15:0]}};
                store_be   = lat_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_data = lat_wdata;
                store_be   = 4'b1111;
            end
        endcase
    end

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign mem_req    = (state == ACCESS);
    assign mem_we     = mem_req && lat_we;
    assign mem_addr   = mem_req ? {lat_addr[31:2], 2'b00} : 32'h0;
    assign mem_wdata  = mem_we ? store_data : 32'h0;
    assign mem_be     = mem_we ? store_be : 4'b0000;
    assign resp_valid = (state == RESP);
    assign resp_data  = resp_valid ? resp_data_q : 32'h0;
    assign resp_err   = resp_valid && resp_err_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multi-cycle load/store sequencer between the MEM-stage pipeline register and a variable-latency data memory.
- Accepts one access at a time over a valid/ready handshake.
- Checks alignment, generates store byte enables and lane-replicated write data, and drives a req/ack memory handshake with a timeout.
- Returns sign- or zero-extended load data with a one-cycle response pulse; the pipeline stalls on busy.

Parameters:
- TIMEOUT, 255, number of ACCESS-state cycles without mem_ack before the access is aborted with an error.
- TIMEOUT_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  pipeline presents an access
- req_ready  output  1  controller can accept; high only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_type  input  3  000 word, 001 byte signed, 010 half signed, 101 byte unsigned, 110 half unsigned; 011/100/111 illegal
- req_addr  input  32  byte address
- req_wdata  input  32  store data; the low byte/half is used for sub-word stores
- mem_req  output  1  memory request, held until mem_ack or timeout
- mem_we  output  1  write strobe qualifier
- mem_addr  output  32  {req_addr[31:2], 2'b00}
- mem_wdata  output  32  lane-replicated store data
- mem_be  output  4  byte enables; 0000 for loads
- mem_ack  input  1  memory completed; meaningful only while mem_req=1
- mem_rdata  input  32  read word, valid in the cycle mem_ack=1
- resp_valid  output  1  one-cycle completion pulse
- resp_data  output  32  extended load result; 0 for stores and errors
- resp_err  output  1  misaligned, illegal type or timeout; valid with resp_valid
- busy  output  1  high in ACCESS and RESP

Behaviour:
- Reset:
  - state=IDLE, timeout counter=0.
  - All outputs 0 except req_ready=1.
  - Reset mid-access drops mem_req on that edge; any later mem_ack is ignored; no response is produced for the aborted access.
- IDLE: req_ready=1.
  - On req_valid&req_ready, latch we/type/addr/wdata.
  - If the access is legal, go to ACCESS.
  - If misaligned (half with addr[0]=1; word with addr[1:0]!=00) or the type is illegal, go to RESP with err=1 and no memory request.
- ACCESS: mem_req=1 with mem_we/mem_addr/mem_wdata/mem_be held stable from the latched values.
  - On mem_ack=1, capture the extracted load data and go to RESP (err=0).
  - Else increment the counter; when counter==TIMEOUT-1 without ack, go to RESP with err=1.
  - An ack arriving in the same cycle as the timeout wins (success).
- RESP: resp_valid=1 for exactly one cycle with resp_data/resp_err; next state IDLE, counter cleared. req_ready=0 in RESP.
- Latency:
  - Request accepted at edge t.
  - mem_req is high during cycle t..; an ack in that first cycle gives resp_valid in the next cycle (minimum 2 cycles accept-to-response).
  - Error paths give resp_valid in the cycle after accept.
- Store lanes:
  - byte: mem_wdata={4{wdata[7:0]}}, mem_be=0001<<addr[1:0].
  - half: mem_wdata={2{wdata[15:0]}}, mem_be=addr[1]?1100:0011.
  - word: mem_wdata=wdata, mem_be=1111.
  - Signed and unsigned types store identically.
- Load extraction:
  - byte: select lane addr[1:0] (00→[7:0] … 11→[31:24]).
  - half: select addr[1] (0→[15:0], 1→[31:16]).
  - Types 001/010 sign-extend; 101/110 zero-extend; word passes through.
- mem_ack outside ACCESS is ignored. req_valid outside IDLE is ignored; the request is not latched and the pipeline holds it.
- mem_be=0000 and mem_wdata=0 whenever mem_req=0.

Test Plan:
- Load byte signed, addr=0x0000_1003, mem_rdata=0x80FF_1234, ack on first ACCESS cycle -> mem_addr=0x0000_1000, mem_be=0000, resp_valid 2 cycles after accept, resp_data=0xFFFF_FF80, resp_err=0.
- Load half unsigned, addr=0x0000_2002, mem_rdata=0x8001_7FFF, ack after 3 wait cycles -> resp_data=0x0000_8001; busy high throughout; req_ready=0 until the cycle after resp_valid.
- Store half, addr=0x0000_3002, wdata=0xDEAD_BEEF -> mem_we=1, mem_be=1100, mem_wdata=0xBEEF_BEEF; resp_data=0, resp_err=0.
- Word load at addr=0x0000_4001 and type=011 at an aligned address -> no mem_req ever asserted; resp_valid the cycle after accept with resp_err=1.
- TIMEOUT=4, never ack -> mem_req high exactly 4 cycles, then resp_err=1; then ack on the same cycle as the final count -> success response.
- Reset asserted during the 2nd ACCESS cycle -> mem_req=0 and req_ready=1 after that edge; a subsequent mem_ack produces no resp_valid; a new request completes normally.
